// File: rtl/apb_arb_master.sv
// apb_arb_master
//   Two-requester APB master. Commands arrive on two valid/ready ports, are
//   arbitrated round-robin, sequenced through SETUP/ACCESS on the APB bus and
//   completed with a one-cycle done pulse (plus read data) to the originator.
//
// Ports
//   clk, Rst                 clock (rising edge), async active-low reset
//   reqN_valid/ready         command handshake (ready is combinational)
//   reqN_write/addr/wdata    command fields, sampled on acceptance
//   reqN_done/rdata          completion pulse and read data
//   PAddr/PWData/PWrite      APB request, held between transfers
//   PSel/PEnable             APB phase control
//   PRData                   APB read data
//   busy                     transfer in flight (SETUP or ACCESS)
module apb_arb_master #(
   parameter int ADDR_W = 16,
   parameter int DATA_W = 32
) (
   input  logic              clk,
   input  logic              Rst,
   input  logic              req0_valid,
   output logic              req0_ready,
   input  logic              req0_write,
   input  logic [ADDR_W-1:0] req0_addr,
   input  logic [DATA_W-1:0] req0_wdata,
   output logic              req0_done,
   output logic [DATA_W-1:0] req0_rdata,
   input  logic              req1_valid,
   output logic              req1_ready,
   input  logic              req1_write,
   input  logic [ADDR_W-1:0] req1_addr,
   input  logic [DATA_W-1:0] req1_wdata,
   output logic              req1_done,
   output logic [DATA_W-1:0] req1_rdata,
   output logic [ADDR_W-1:0] PAddr,
   output logic [DATA_W-1:0] PWData,
   output logic              PWrite,
   output logic              PSel,
   output logic              PEnable,
   input  logic [DATA_W-1:0] PRData,
   output logic              busy
);

   typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;

   state_t state, state_nxt;
   logic   last_grant;   // 1 = requester 1 was granted last
   logic   owner;        // requester of the in-flight command
   logic   slot, pick1, accept;

   // PSel/PEnable/busy decode straight from state so reset clears them
   // without waiting for a clock edge.
   always_comb begin
      slot       = (state == IDLE) || (state == ACCESS);
      // req1 wins when alone, or on a tie when req0 was granted last
      pick1      = req1_valid && (!req0_valid || !last_grant);
      req0_ready = slot && req0_valid && !pick1;
      req1_ready = slot && pick1;
      accept     = req0_ready || req1_ready;
      PSel       = (state != IDLE);
      PEnable    = (state == ACCESS);
      busy       = PSel;
      state_nxt  = state;
      case (state)
         IDLE:    if (accept) state_nxt = SETUP;
         SETUP:   state_nxt = ACCESS;
         ACCESS:  state_nxt = accept ? SETUP : IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge Rst) begin
      if (!Rst) state <= IDLE;
      else      state <= state_nxt;
   end

   always_ff @(posedge clk or negedge Rst) begin
      if (!Rst) begin
         PAddr      <= '0;
         PWData     <= '0;
         PWrite     <= 1'b0;
         owner      <= 1'b0;
         last_grant <= 1'b1;
         req0_done  <= 1'b0;
         req1_done  <= 1'b0;
         req0_rdata <= '0;
         req1_rdata <= '0;
      end else begin
         if (accept) begin
            PWrite     <= pick1 ? req1_write : req0_write;
            PAddr      <= pick1 ? req1_addr  : req0_addr;
            PWData     <= pick1 ? req1_wdata : req0_wdata;
            owner      <= pick1;
            last_grant <= pick1;
         end
         // completion uses the pre-edge owner/PWrite, so a command accepted
         // in this same ACCESS cycle does not disturb it
         req0_done <= (state == ACCESS) && !owner;
         req1_done <= (state == ACCESS) &&  owner;
         if (state == ACCESS && !PWrite) begin
            if (owner) req1_rdata <= PRData;
            else       req0_rdata <= PRData;
         end
      end
   end

endmodule
